// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch stage.
// Fetched words are held for decode behind a valid/ready handshake; branches discard in-flight work.
module pc_fetch_unit #(
    parameter int unsigned          PC_WIDTH    = 16,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
    parameter int unsigned          INSTR_BYTES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PC_WIDTH-1:0] target_pc,
    input  logic                branch_taken,
    input  logic                stall,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic                imem_rvalid,
    input  logic [15:0]         imem_rdata,
    output logic                instr_valid,
    output logic [15:0]         instr,
    output logic [PC_WIDTH-1:0] instr_pc,
    input  logic                instr_ready,
    output logic [PC_WIDTH-1:0] pc
);

    localparam logic [PC_WIDTH-1:0] PcIncr = PC_WIDTH'(INSTR_BYTES);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic [15:0]         instr_q, instr_d;
    logic                instr_valid_q, instr_valid_d;
    logic                drop_q, drop_d;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                req_fire;

    assign redirect_pc = {target_pc[PC_WIDTH-1:1], 1'b0};
    assign imem_req    = (state_q == StReq) && !stall && !branch_taken;
    assign imem_addr   = pc_q;
    assign req_fire    = imem_req && imem_ready;

    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        drop_d        = drop_q;

        case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (req_fire) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    // A redirect in the same cycle as the response kills it too.
                    if (drop_q || branch_taken) begin
                        drop_d  = 1'b0;
                        state_d = StReq;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc_q;
                        pc_d          = pc_q + PcIncr;
                        instr_valid_d = 1'b1;
                        state_d       = StHold;
                    end
                end else if (branch_taken) begin
                    drop_d = 1'b1;
                end
            end
            StHold: begin
                if (branch_taken || instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = StReq;
                end
            end
            default: state_d = StIdle;
        endcase

        // Redirect overrides any sequential increment in the same cycle.
        if (branch_taken) begin
            pc_d = redirect_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            drop_q        <= drop_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed fetch, redirect, wrap, stall and reset scenarios.
// A responder models instruction memory; a monitor checks requests and delivered instructions.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] target_pc;
    logic        branch_taken;
    logic        stall;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic [15:0] pc;

    int n_cmp = 0;
    int n_err = 0;
    int n_instr = 0;
    int resp_delay = 1;

    logic [15:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];
    logic [15:0] resp_q[$];

    pc_fetch_unit #(
        .PC_WIDTH   (16),
        .RESET_PC   (16'h0000),
        .INSTR_BYTES(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .target_pc   (target_pc),
        .branch_taken(branch_taken),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting, got none want event", name);
    endtask

    task automatic wait_instr(input int n);
        for (int i = 0; i < 60 && n_instr < n; i++) begin
            @(posedge clk);
            #1;
        end
        if (n_instr < n) timeout("wait_instr");
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 60 && !instr_valid; i++) begin
            @(posedge clk);
            #1;
        end
        if (!instr_valid) timeout("wait_valid");
    endtask

    task automatic wait_accept();
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = imem_req && imem_ready;
        end
        if (!seen) timeout("wait_accept");
    endtask

    // Memory responder: one rvalid per accepted request, resp_delay cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && imem_req && imem_ready) begin
                @(posedge clk);
                #1;
                repeat (resp_delay - 1) begin
                    @(posedge clk);
                    #1;
                end
                imem_rvalid = 1'b1;
                imem_rdata  = (resp_q.size() != 0) ? resp_q.pop_front() : 16'hBAD0;
                @(posedge clk);
                #1;
                imem_rvalid = 1'b0;
            end
        end
    end

    // Monitor: every accepted request and every consumed instruction is checked in order.
    initial begin
        forever begin
            @(negedge clk);
            if (imem_req && imem_ready) begin
                if (exp_addr_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL req_addr: got %h want no request", imem_addr);
                end else begin
                    check("req_addr", {16'h0, imem_addr}, {16'h0, exp_addr_q.pop_front()});
                end
            end
            if (instr_valid && instr_ready && !branch_taken) begin
                n_instr++;
                if (exp_instr_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL instr: got %h@%h want no instruction", instr, instr_pc);
                end else begin
                    check("instr", {instr_pc, instr}, exp_instr_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        target_pc    = 16'h0000;
        branch_taken = 1'b0;
        stall        = 1'b0;
        imem_ready   = 1'b1;
        imem_rvalid  = 1'b0;
        imem_rdata   = 16'h0000;
        instr_ready  = 1'b1;

        // Reset values.
        @(negedge clk);
        check("rst_pc", {16'h0, pc}, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_instr", {16'h0, instr}, 32'h0);
        check("rst_instr_pc", {16'h0, instr_pc}, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'h0);

        // Three sequential fetches; second one held by decode for 4 cycles.
        exp_addr_q.push_back(16'h0000);
        exp_addr_q.push_back(16'h0002);
        exp_addr_q.push_back(16'h0004);
        resp_q.push_back(16'h1234);
        resp_q.push_back(16'h5678);
        resp_q.push_back(16'h9ABC);
        exp_instr_q.push_back({16'h0000, 16'h1234});
        exp_instr_q.push_back({16'h0002, 16'h5678});
        exp_instr_q.push_back({16'h0004, 16'h9ABC});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_instr(1);
        instr_ready = 1'b0;
        wait_valid();
        repeat (4) begin
            @(negedge clk);
            check("hold_valid", {31'h0, instr_valid}, 32'h1);
            check("hold_instr", {instr_pc, instr}, {16'h0002, 16'h5678});
            check("hold_no_req", {31'h0, imem_req}, 32'h0);
        end
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        wait_instr(3);

        // Redirect while waiting for memory: 0xDEAD must be discarded.
        exp_addr_q.push_back(16'h0006);
        exp_addr_q.push_back(16'h0100);
        resp_q.push_back(16'hDEAD);
        resp_q.push_back(16'h4321);
        resp_delay = 3;
        wait_accept();
        @(posedge clk);
        #1;
        branch_taken = 1'b1;
        target_pc    = 16'h0101;
        instr_ready  = 1'b0;
        @(posedge clk);
        #1;
        branch_taken = 1'b0;
        resp_delay   = 1;
        check("redirect_pc", {16'h0, pc}, 32'h0100);
        wait_valid();
        @(negedge clk);
        check("after_drop", {instr_pc, instr}, {16'h0100, 16'h4321});

        // Branch and decode-ready together in HOLD: branch wins.
        @(posedge clk);
        #1;
        exp_addr_q.push_back(16'h0040);
        resp_q.push_back(16'h0F0F);
        exp_instr_q.push_back({16'h0040, 16'h0F0F});
        branch_taken = 1'b1;
        target_pc    = 16'h0040;
        instr_ready  = 1'b1;
        @(posedge clk);
        #1;
        branch_taken = 1'b0;
        @(negedge clk);
        check("hold_branch_valid", {31'h0, instr_valid}, 32'h0);
        check("hold_branch_addr", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0040});
        wait_instr(4);

        // Redirect to 0xFFFF (bit0 cleared) then wrap past the top of the address space.
        exp_addr_q.push_back(16'hFFFE);
        resp_q.push_back(16'hCAFE);
        exp_instr_q.push_back({16'hFFFE, 16'hCAFE});
        stall        = 1'b1;
        branch_taken = 1'b1;
        target_pc    = 16'hFFFF;
        @(posedge clk);
        #1;
        stall        = 1'b0;
        branch_taken = 1'b0;
        check("wrap_target_pc", {16'h0, pc}, 32'hFFFE);
        wait_instr(5);

        // Stall for 5 cycles, then reset in the middle of the next fetch.
        exp_addr_q.push_back(16'h0000);
        resp_q.push_back(16'hBEEF);
        resp_delay = 4;
        stall      = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_no_req", {31'h0, imem_req}, 32'h0);
            check("wrap_pc", {16'h0, pc}, 32'h0);
        end
        @(posedge clk);
        #1;
        stall = 1'b0;
        wait_accept();
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        @(negedge clk);
        check("midrst_pc", {16'h0, pc}, 32'h0);
        check("midrst_valid", {31'h0, instr_valid}, 32'h0);
        check("midrst_instr", {instr_pc, instr}, 32'h0);
        check("midrst_req", {31'h0, imem_req}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("stray_rvalid_valid", {31'h0, instr_valid}, 32'h0);
            check("stray_rvalid_addr", {16'h0, imem_addr}, 32'h0);
        end
        check("stable_req", {31'h0, imem_req}, 32'h1);
        @(posedge clk);
        #1;
        exp_addr_q.push_back(16'h0000);
        resp_q.push_back(16'h7777);
        exp_instr_q.push_back({16'h0000, 16'h7777});
        resp_delay = 1;
        imem_ready = 1'b1;
        wait_instr(6);
        stall = 1'b1;

        repeat (3) @(negedge clk);
        check("addr_q_empty", exp_addr_q.size(), 32'h0);
        check("instr_q_empty", exp_instr_q.size(), 32'h0);
        check("resp_q_empty", resp_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
